digit_glyph_mem: RTL

// - Answers the scoreboard pixel selector's glyph-line requests; each answer is one 32-pixel line of a 32x32 digit.
// - Holds the MM:SS timer: minutes 0-9, tens of seconds 0-5, seconds 0-9.
// - Renders digits procedurally as 7-segment glyphs, so no font ROM is needed.
// - Sits between the timer tick source and the selector: consumes digit_sel/en_mem/line_sel, returns line_buffer.

---
 rtl/digit_glyph_mem.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/digit_glyph_mem.sv
// digit_glyph_mem
//   MM:SS timer with a per-frame snapshot, and procedurally rendered
//   7-segment 32x32 digit glyphs served one line per request.
//
//   Build option: define LEADING_ZERO_BLANK_EN to blank the minute digit
//   while it reads 0. Seconds digits are never blanked.
//
//   Ports
//     clk_mem      in   1   system clock, rising edge
//     rst_mem      in   1   synchronous reset, active low
//     tick_1hz     in   1   one-second pulse, counts when run_tmr=1
//     run_tmr      in   1   1 = count, 0 = hold
//     clr_tmr      in   1   synchronous clear to 0:00 (beats tick_1hz)
//     frame_start  in   1   copies the timer into the display registers
//     digit_sel    in   2   01 = sec, 10 = ten_sec, 11 = min, 00 = none
//     en_mem       in   1   read request strobe
//     line_sel     in   5   glyph line 0..31, 0 = top
//     line_buffer  out  32  glyph line, bit 31 = leftmost column
//     rd_valid     out  1   line_buffer holds the answer to last cycle's request
//     tmr_wrap     out  1   one-cycle pulse on MAX_MIN:59 -> 0:00
module digit_glyph_mem #(
   parameter int unsigned SEG_T    = 4,
   parameter int unsigned MID_LINE = 14,
   parameter int unsigned MAX_MIN  = 9
) (
   input  logic        clk_mem,
   input  logic        rst_mem,
   input  logic        tick_1hz,
   input  logic        run_tmr,
   input  logic        clr_tmr,
   input  logic        frame_start,
   input  logic [1:0]  digit_sel,
   input  logic        en_mem,
   input  logic [4:0]  line_sel,
   output logic [31:0] line_buffer,
   output logic        rd_valid,
   output logic        tmr_wrap
);

   logic [3:0]  tmr_min, tmr_ten, tmr_sec;
   logic [3:0]  disp_min, disp_ten, disp_sec;
   logic        step;
   logic        sec_last, ten_last, min_last;
   logic [3:0]  rd_digit;
   logic        rd_blank;
   logic [31:0] rd_line;

   // Segment bits are ordered {A,B,C,D,E,F,G}.
   function automatic logic [31:0] glyph(input logic [3:0] d, input logic [4:0] l);
      logic [6:0]  s;
      logic [31:0] row;
      int unsigned li;
      logic        left, mid, right, on;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = '0;
      endcase
      li  = 32'(l);
      row = '0;
      for (int unsigned c = 0; c < 32; c++) begin
         left  = (c < SEG_T);
         right = (c >= 32 - SEG_T);
         mid   = !left && !right;
         on = (s[6] && mid   && li < SEG_T)
           || (s[0] && mid   && li >= MID_LINE && li < MID_LINE + SEG_T)
           || (s[3] && mid   && li >= 32 - SEG_T)
           || (s[1] && left  && li < MID_LINE + SEG_T)
           || (s[5] && right && li < MID_LINE + SEG_T)
           || (s[2] && left  && li >= MID_LINE)
           || (s[4] && right && li >= MID_LINE);
         row[5'(31 - c)] = on;
      end
      return row;
   endfunction

   assign step     = tick_1hz && run_tmr;
   assign sec_last = (tmr_sec == 4'd9);
   assign ten_last = (tmr_ten == 4'd5);
   assign min_last = (tmr_min == 4'(MAX_MIN));

   always_ff @(posedge clk_mem) begin
      if (!rst_mem) begin
         tmr_min  <= '0;
         tmr_ten  <= '0;
         tmr_sec  <= '0;
         tmr_wrap <= 1'b0;
      end else if (clr_tmr) begin
         tmr_min  <= '0;
         tmr_ten  <= '0;
         tmr_sec  <= '0;
         tmr_wrap <= 1'b0;
      end else begin
         tmr_wrap <= step && sec_last && ten_last && min_last;
         if (step) begin
            if (!sec_last) begin
               tmr_sec <= tmr_sec + 4'd1;
            end else begin
               tmr_sec <= '0;
               if (!ten_last) begin
                  tmr_ten <= tmr_ten + 4'd1;
               end else begin
                  tmr_ten <= '0;
                  tmr_min <= min_last ? '0 : tmr_min + 4'd1;
               end
            end
         end
      end
   end

   // Captures the pre-update timer, so a tick on the same edge shows next frame.
   always_ff @(posedge clk_mem) begin
      if (!rst_mem) begin
         disp_min <= '0;
         disp_ten <= '0;
         disp_sec <= '0;
      end else if (frame_start) begin
         disp_min <= tmr_min;
         disp_ten <= tmr_ten;
         disp_sec <= tmr_sec;
      end
   end

   always_comb begin
      rd_digit = '0;
      rd_blank = 1'b1;
      case (digit_sel)
         2'b01: begin rd_digit = disp_sec; rd_blank = 1'b0; end
         2'b10: begin rd_digit = disp_ten; rd_blank = 1'b0; end
         2'b11: begin
            rd_digit = disp_min;
`ifdef LEADING_ZERO_BLANK_EN
            rd_blank = (disp_min == 4'd0);
`else
            rd_blank = 1'b0;
`endif
         end
         default: begin rd_digit = '0; rd_blank = 1'b1; end
      endcase
      rd_line = rd_blank ? '0 : glyph(rd_digit, line_sel);
   end

   always_ff @(posedge clk_mem) begin
      if (!rst_mem) begin
         line_buffer <= '0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= en_mem;
         if (en_mem) begin
            line_buffer <= rd_line;
         end
      end
   end

endmodule
